// File: rtl/ripple_adder_10b_pkg.sv
// Shared definitions for the 10-bit processor datapath.
// The word width is also used by the ALU and the register file.
package ripple_adder_10b_pkg;

    localparam int DATA_W = 10;

endpackage

// File: rtl/ripple_adder_10b_full_adder_cell.sv
// Single-bit full adder. The ripple adder chains one of these per bit.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign s       = halfSum ^ ci;
    assign co      = (a & b) | (ci & halfSum);

endmodule

// File: rtl/ripple_adder_10b.sv
// Registered ripple-carry adder: a full_adder_cell chain feeding one output register.
// Define RIPPLE_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module ripple_adder_10b
    import ripple_adder_10b_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef RIPPLE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sumComb;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             valid_q;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        full_adder_cell u_fa (
            .a  (A[gi]),
            .b  (B[gi]),
            .ci (carry[gi]),
            .s  (sumComb[gi]),
            .co (carry[gi+1])
        );
    end

    // Results are captured only on qualified cycles; otherwise the last result is held.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        if (in_valid) begin
            sum_d  = sumComb;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= in_valid;
        end
    end

`ifdef RIPPLE_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_adder_10b.sv
// Self-checking bench for ripple_adder_10b: directed cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_ripple_adder_10b;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
    logic         ovf;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit checkEnable = 1'b0;

    logic [W-1:0] expSum = '0;
    logic         expCout = 1'b0;
    logic         expValid = 1'b0;
    logic         expOvf = 1'b0;

    ripple_adder_10b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
`ifdef RIPPLE_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the sampled operands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expSum   <= '0;
            expCout  <= 1'b0;
            expValid <= 1'b0;
            expOvf   <= 1'b0;
        end else begin
            expValid <= in_valid;
            if (in_valid) begin
                int total;
                int signedTotal;
                total       = int'(A) + int'(B) + int'(cin);
                signedTotal = int'($signed(A)) + int'($signed(B)) + int'(cin);
                expSum  <= W'(total % 1024);
                expCout <= (total >= 1024);
                expOvf  <= (signedTotal > 511) || (signedTotal < -512);
            end
        end
    end

    // Every cycle, the registered outputs must match the model.
    always @(negedge clk) begin
        if (checkEnable) begin
            vectors++;
            if (sum !== expSum || cout !== expCout || out_valid !== expValid) begin
                miscompares++;
                $display("[TB] FAIL model t=%0t: got sum=%0d cout=%b vld=%b, expected sum=%0d cout=%b vld=%b",
                         $time, sum, cout, out_valid, expSum, expCout, expValid);
            end
`ifdef RIPPLE_ADDER_OVF_EN
            vectors++;
            if (ovf !== expOvf) begin
                miscompares++;
                $display("[TB] FAIL model_ovf t=%0t: got ovf=%b, expected %b", $time, ovf, expOvf);
            end
`endif
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic v);
        @(negedge clk);
        A        = a;
        B        = b;
        cin      = c;
        in_valid = v;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] s,
                               input logic c, input logic v);
        vectors++;
        if (sum !== s || cout !== c || out_valid !== v) begin
            miscompares++;
            $display("[TB] FAIL %s: got sum=%0d cout=%b vld=%b, expected sum=%0d cout=%b vld=%b",
                     name, sum, cout, out_valid, s, c, v);
        end
    endtask

`ifdef RIPPLE_ADDER_OVF_EN
    task automatic checkOvf(input string name, input logic o);
        vectors++;
        if (ovf !== o) begin
            miscompares++;
            $display("[TB] FAIL %s: got ovf=%b, expected %b", name, ovf, o);
        end
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEnable = 1'b1;
        checkOutput("reset_initial", 10'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Activity, then asynchronous reset mid-cycle with a result in flight.
        applyStimulus(10'd7, 10'd8, 1'b0, 1'b1);
        applyStimulus(10'd9, 10'd9, 1'b1, 1'b1);
        checkOutput("pre_reset", 10'd15, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", 10'd0, 1'b0, 1'b0);
        applyStimulus(10'd15, 10'd10, 1'b0, 1'b1);
        rst_n = 1'b1;
        applyStimulus(10'd20, 10'd1015, 1'b1, 1'b1);
        checkOutput("add_15_10", 10'd25, 1'b0, 1'b1);

        applyStimulus(10'd5, 10'd1013, 1'b1, 1'b1);
        checkOutput("sub_20_8", 10'd12, 1'b1, 1'b1);
        applyStimulus(10'd1023, 10'd0, 1'b1, 1'b1);
        checkOutput("sub_5_10", 10'd1019, 1'b0, 1'b1);
        applyStimulus(10'd1023, 10'd1023, 1'b1, 1'b1);
        checkOutput("wrap_ones_cin", 10'd0, 1'b1, 1'b1);
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1);
        checkOutput("wrap_max_max", 10'd1023, 1'b1, 1'b1);

        applyStimulus(10'd1, 10'd2, 1'b0, 1'b1);
        checkOutput("zero_zero", 10'd0, 1'b0, 1'b1);
        applyStimulus(10'd100, 10'd200, 1'b0, 1'b1);
        checkOutput("b2b_1", 10'd3, 1'b0, 1'b1);
        applyStimulus(10'd512, 10'd512, 1'b0, 1'b1);
        checkOutput("b2b_2", 10'd300, 1'b0, 1'b1);
        applyStimulus(10'd333, 10'd444, 1'b1, 1'b0);
        checkOutput("b2b_3", 10'd0, 1'b1, 1'b1);
        applyStimulus(10'd511, 10'd1, 1'b0, 1'b1);
        checkOutput("idle_hold", 10'd0, 1'b1, 1'b0);

        applyStimulus(10'd1023, 10'd1, 1'b0, 1'b1);
        checkOutput("carry_chain", 10'd512, 1'b0, 1'b1);
`ifdef RIPPLE_ADDER_OVF_EN
        checkOvf("ovf_511_1", 1'b1);
`endif
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
        checkOutput("neg1_plus_1", 10'd0, 1'b1, 1'b1);
`ifdef RIPPLE_ADDER_OVF_EN
        checkOvf("ovf_m1_1", 1'b0);
`endif

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkEnable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
